systolic_feeder: RTL and testbench
==================================

# systolic_feeder

Front-end sequencer for the N×N systolic multiply array: accepts one k-slice per beat (column k of A, row k of B) over a valid/ready handshake and drives the array's left-edge `l_d_i` lanes and top-edge `t_d_i` lanes. It sequences a whole job: clear accumulators, feed K beats with per-column skew, flush the skew, then assert read for N cycles. During read, the array's left-column outputs present one result column per cycle to the downstream collector.

## Interface
- `N`, 4: array dimension (rows = columns = lanes)
- `W`, 16: lane data width
- `KW`, 16: width of the beat count `k_len`

- `clk`  in  1  clock, all state updates on rising edge
- `reset_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  job request; sampled only in IDLE
- `k_len`  in  KW  beats in the job (K); sampled with `start`
- `busy`  out  1  high from CLEAR through the last READ cycle
- `done`  out  1  one-cycle pulse after the last READ cycle
- `in_valid`  in  1  beat available
- `in_ready`  out  1  feeder accepts the beat this cycle
- `a_col`  in  N*W  lane i = A[i][k]
- `b_row`  in  N*W  lane j = B[k][j]
- `pe_clear`  out  1  to every PE `reset` (clears accumulator)
- `pe_read`  out  1  to every PE `read` (shift-out mode)
- `l_d`  out  N*W  lane i drives `l_d_i` of array row i, column 0
- `t_d`  out  N*W  lane j drives `t_d_i` of every PE in array column j
- `res_valid`  out  1  array left-column outputs hold a result column
- `res_col`  out  $clog2(N)  index of the result column currently presented

## Operation
- Skew rule: left data hops one PE per cycle and top data is broadcast down each column. Row lanes are therefore unskewed and column lane j is delayed j extra cycles. PE(i,j) then multiplies A[i][k]·B[k][j] for the same k.
- States:
  - IDLE: `start`=1 → CLEAR; `k_len` latched into the remaining-beat counter.
  - CLEAR: one cycle, `pe_clear`=1 → FEED, or → FLUSH if K=0.
  - FEED: `in_ready`=1 (combinational from state). Each `in_valid && in_ready` edge accepts a beat and decrements the counter. The last accepted beat → FLUSH.
  - FLUSH: N cycles, `in_ready`=0 → READ.
  - READ: N cycles, `pe_read`=1, `res_valid`=1, `res_col` counts 0..N-1 → IDLE with `done` pulse.
- Accepted beat: `l_d` lane i registers `a_col` lane i. `b_row` lane j enters a zero-initialised shift chain of length j+1, whose tail drives `t_d` lane j.
- Bubble (FEED with `in_valid`=0), and every cycle outside FEED: zeros are registered into `l_d` and shifted into every `t_d` chain. A zero beat contributes 0 to every accumulator, so bubbles are legal at any point in FEED.
- Arithmetic: the feeder passes data unmodified. Products and sums wrap mod 2^W inside the PEs.
- `start` while busy is ignored. `in_valid` outside FEED is ignored and never consumed.

## Timing
- Reset values (async, immediate): state IDLE; `busy`, `done`, `in_ready`, `pe_clear`, `pe_read`, `res_valid` = 0; `res_col` = 0; `l_d`, `t_d`, all chain stages and the beat counter = 0.
- Latency: a beat accepted at edge e appears on `l_d` after e. Lane j of `t_d` shows it j cycles later.
- FLUSH length N covers the 1-cycle output register plus the N-1 skew. The last product lands in PE(i,N-1) before READ starts.
- READ cycle r: the PE row-i left output combinationally equals C[i][r]. `res_col` = r.
- Job length without bubbles: 1 + K + 2N cycles from the `start` edge to the last READ cycle. `done` is high the following cycle, with state in IDLE and `busy`=0.
- Back-to-back jobs: `start` may be high in the `done` cycle, which begins CLEAR on the next edge.
- `reset_n` low mid-job: abort immediately to reset values. PE accumulators are not cleared by this, but the next job's CLEAR does it.

## Test plan
- N=4, A=I, B rows [1,2,3,4],[5,6,7,8],[9,10,11,12],[13,14,15,16], K=4, no bubbles → READ r presents column r of B. `done` 13 cycles after `start`.
- Same job with `in_valid` low on alternate cycles → identical results. `busy` extends by 4 cycles.
- A = all 0x0100, B = all 0x0100, K=4 → every C = 0 (wraps mod 2^16). Then a second back-to-back job with A=B=all 1, K=3 → every C = 3, proving CLEAR works.
- K=0 → CLEAR, FLUSH, READ. All results 0. `in_ready` never asserted.
- `reset_n` pulsed low in FEED after 2 beats → all outputs 0 at once. A fresh K=4 identity job then returns exact B.
- `start` pulsed during FEED and READ → ignored. `in_valid` held high in FLUSH/READ → no beats consumed.

Source files
------------

// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - job sequencer and skewed lane driver for an NxN systolic array
//
// Runs one matrix job: CLEAR, FEED (K beats), FLUSH (N), READ (N), then a done pulse.
//   clk, reset_n        : clock, asynchronous active-low reset
//   start, k_len        : job request and beat count, sampled only in IDLE
//   busy, done          : job in progress / one-cycle completion pulse
//   in_valid, in_ready  : beat handshake (a_col = column k of A, b_row = row k of B)
//   pe_clear, pe_read   : broadcast PE accumulator clear / shift-out controls
//   l_d, t_d            : left-edge row lanes / top-edge column lanes of the array
//   res_valid, res_col  : result column presented on the array's left outputs
module systolic_feeder #(
  parameter int N  = 4,
  parameter int W  = 16,
  parameter int KW = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [KW-1:0]          k_len,
  output logic                   busy,
  output logic                   done,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N*W-1:0]         a_col,
  input  logic [N*W-1:0]         b_row,
  output logic                   pe_clear,
  output logic                   pe_read,
  output logic [N*W-1:0]         l_d,
  output logic [N*W-1:0]         t_d,
  output logic                   res_valid,
  output logic [$clog2(N)-1:0]   res_col
);

  localparam int CW = $clog2(N);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_FLUSH = 3'd3,
    S_READ  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   cnt_q, cnt_d;     // beats still to accept
  logic [CW-1:0]   ph_q, ph_d;       // cycle index inside FLUSH / READ
  logic            done_q, done_d;
  logic [N*W-1:0]  l_d_q;
  logic            accept;

  assign accept = (state_q == S_FEED) && in_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ph_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ph_q    <= ph_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ph_d    = ph_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
          cnt_d   = k_len;
        end
      end
      S_CLEAR: begin
        ph_d    = '0;
        state_d = (cnt_q == '0) ? S_FLUSH : S_FEED;
      end
      S_FEED: begin
        if (in_valid) begin
          cnt_d = cnt_q - KW'(1);
          if (cnt_q == KW'(1)) begin
            state_d = S_FLUSH;
            ph_d    = '0;
          end
        end
      end
      S_FLUSH: begin
        if (ph_q == CW'(N - 1)) begin
          state_d = S_READ;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + CW'(1);
        end
      end
      S_READ: begin
        if (ph_q == CW'(N - 1)) begin
          state_d = S_IDLE;
          ph_d    = '0;
          done_d  = 1'b1;
        end else begin
          ph_d = ph_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        ph_d    = '0;
      end
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign in_ready  = (state_q == S_FEED);
  assign pe_clear  = (state_q == S_CLEAR);
  assign pe_read   = (state_q == S_READ);
  assign res_valid = (state_q == S_READ);
  // ph_q also runs during FLUSH; only expose it while a result column is presented.
  assign res_col   = (state_q == S_READ) ? ph_q : '0;

  // Row lanes are unskewed: the array itself delays left data one PE per column.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      l_d_q <= '0;
    end else begin
      l_d_q <= accept ? a_col : '0;
    end
  end
  assign l_d = l_d_q;

  // Column lane j is broadcast down its column, so it must lag the row data by j
  // cycles to meet the matching A element at PE(i,j): a chain of j+1 registers.
  for (genvar j = 0; j < N; j++) begin : g_lane
    logic [W-1:0] sh_q [0:j];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int s = 0; s <= j; s++) begin
          sh_q[s] <= '0;
        end
      end else begin
        sh_q[0] <= accept ? b_row[j*W +: W] : '0;
        for (int s = 1; s <= j; s++) begin
          sh_q[s] <= sh_q[s-1];
        end
      end
    end

    assign t_d[j*W +: W] = sh_q[j];
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// tb/tb_systolic_feeder.sv - randomized self-checking bench for systolic_feeder
module tb_systolic_feeder;

  localparam int N    = 4;
  localparam int W    = 16;
  localparam int KW   = 16;
  localparam int KMAX = 8;
  localparam int CW   = $clog2(N);

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            start = 1'b0;
  logic [KW-1:0]   k_len = '0;
  logic            busy, done, in_ready, pe_clear, pe_read, res_valid;
  logic            in_valid = 1'b0;
  logic [N*W-1:0]  a_col = '0;
  logic [N*W-1:0]  b_row = '0;
  logic [N*W-1:0]  l_d, t_d;
  logic [CW-1:0]   res_col;

  int n_checks = 0;
  int n_errors = 0;

  // Job operands and an behavioural NxN PE array driven by the feeder outputs.
  logic [W-1:0] ma [N][KMAX];
  logic [W-1:0] mb [KMAX][N];
  logic [W-1:0] acc [N][N];
  logic [W-1:0] hist [N][N];   // hist[d][i] = l_d lane i from d cycles ago

  systolic_feeder #(.N(N), .W(W), .KW(KW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .k_len(k_len),
    .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready),
    .a_col(a_col), .b_row(b_row), .pe_clear(pe_clear), .pe_read(pe_read),
    .l_d(l_d), .t_d(t_d), .res_valid(res_valid), .res_col(res_col)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_c(input int i, input int j, input int k);
    logic [W-1:0] s = '0;
    for (int kk = 0; kk < k; kk++) s = s + ma[i][kk] * mb[kk][j];
    return s;
  endfunction

  // One array cycle: PE(i,j) sees row-i data that has hopped j PEs and the column-j lane.
  task automatic model_step();
    for (int d = N - 1; d > 0; d--)
      for (int i = 0; i < N; i++) hist[d][i] = hist[d-1][i];
    for (int i = 0; i < N; i++) hist[0][i] = l_d[i*W +: W];
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (pe_clear) acc[i][j] = '0;
        else if (!pe_read) acc[i][j] = acc[i][j] + hist[j][i] * t_d[j*W +: W];
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    model_step();
  endtask

  task automatic garbage();
    a_col = {$urandom(), $urandom()};
    b_row = {$urandom(), $urandom()};
  endtask

  task automatic drive_beat(input int k);
    for (int i = 0; i < N; i++) a_col[i*W +: W] = ma[i][k];
    for (int j = 0; j < N; j++) b_row[j*W +: W] = mb[k][j];
  endtask

  task automatic set_identity();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < KMAX; k++) ma[i][k] = (i == k) ? 16'd1 : 16'd0;
    for (int k = 0; k < KMAX; k++)
      for (int j = 0; j < N; j++) mb[k][j] = W'(4 * k + j + 1);
  endtask

  task automatic set_fill(input logic [W-1:0] va, input logic [W-1:0] vb);
    for (int i = 0; i < N; i++)
      for (int k = 0; k < KMAX; k++) begin
        ma[i][k] = va;
        mb[k][i] = vb;
      end
  endtask

  task automatic set_random();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < KMAX; k++) begin
        ma[i][k] = W'($urandom());
        mb[k][i] = W'($urandom());
      end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_pe_clear"}, pe_clear, 0);
    check({tag, "_pe_read"}, pe_read, 0);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_res_col"}, res_col, 0);
    check({tag, "_l_d"}, l_d, 0);
    check({tag, "_t_d"}, t_d, 0);
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      in_valid = 1'($urandom());
      garbage();
      tick();
      check("idle_done", done, 0);
      check_quiet("idle");
    end
    in_valid = 1'b0;
  endtask

  // bub: 0 none, 1 alternate cycles, 2 random.  abort_at: beats before reset (-1 none).
  task automatic run_job(input int k, input int bub, input int abort_at, input bit poke);
    int  beats = 0;
    int  cyc = 0;
    bit  v;
    start = 1'b1;
    k_len = KW'(k);
    tick();
    start = 1'b0;
    k_len = KW'($urandom());
    check("clear_pe_clear", pe_clear, 1);
    check("clear_busy", busy, 1);
    check("clear_in_ready", in_ready, 0);
    check("clear_done", done, 0);
    in_valid = 1'b1;
    garbage();
    tick();
    while (beats < k) begin
      if (beats == abort_at) begin
        reset_n = 1'b0;
        #1;
        check("abort_done", done, 0);
        check_quiet("abort");
        in_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        return;
      end
      check("feed_in_ready", in_ready, 1);
      check("feed_busy", busy, 1);
      check("feed_pe_read", pe_read, 0);
      case (bub)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      in_valid = v;
      if (v) drive_beat(beats);
      else garbage();
      start = poke && (cyc == 1);
      tick();
      if (v) beats++;
      cyc++;
    end
    start = 1'b0;
    for (int f = 0; f < N; f++) begin
      check("flush_in_ready", in_ready, 0);
      check("flush_busy", busy, 1);
      check("flush_pe_read", pe_read, 0);
      in_valid = 1'b1;
      garbage();
      tick();
    end
    for (int r = 0; r < N; r++) begin
      check("read_pe_read", pe_read, 1);
      check("read_res_valid", res_valid, 1);
      check("read_res_col", res_col, r);
      check("read_in_ready", in_ready, 0);
      check("read_l_d", l_d, 0);
      check("read_t_d", t_d, 0);
      for (int i = 0; i < N; i++)
        check($sformatf("c[%0d][%0d]_k%0d", i, r, k), acc[i][r], exp_c(i, r, k));
      in_valid = 1'b1;
      garbage();
      start = poke && (r == 1);
      tick();
    end
    start = 1'b0;
    in_valid = 1'b0;
    check("done_pulse", done, 1);
    check("done_busy", busy, 0);
    check("done_in_ready", in_ready, 0);
    check("done_pe_read", pe_read, 0);
  endtask

  initial begin
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        acc[i][j]  = '0;
        hist[i][j] = '0;
      end
    repeat (2) @(negedge clk);
    check("reset_done", done, 0);
    check_quiet("reset");
    reset_n = 1'b1;
    @(negedge clk);

    set_identity();
    run_job(4, 0, -1, 0);
    idle(2);
    run_job(4, 1, -1, 0);
    idle(2);

    set_fill(16'h0100, 16'h0100);
    run_job(4, 0, -1, 0);
    set_fill(16'h0001, 16'h0001);
    run_job(3, 0, -1, 0);
    idle(1);

    run_job(0, 0, -1, 0);
    idle(2);

    set_identity();
    run_job(4, 0, 2, 0);
    run_job(4, 0, -1, 0);
    idle(1);

    set_random();
    run_job(4, 2, -1, 1);
    idle(1);

    repeat (6) begin
      set_random();
      run_job($urandom_range(1, KMAX), 2, -1, 1'($urandom()));
      if ($urandom_range(0, 1) == 1) idle(1);
    end
    idle(1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
